neuron_output: RTL and testbench
================================

NEURON_OUTPUT -- requirements
Module: neuron_output

Interface
REQ-001 Parameter N, default 6: number of neuron inputs (N >= 1).
REQ-002 Parameter BITS, default 16: word width, signed two's-complement Q8.8.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 load  in  1  capture w_in/b_in into weight registers (IDLE only).
REQ-006 w_in  in  N x BITS  initial weights;  b_in  in  BITS  initial bias.
REQ-007 start  in  1  begin a pass (IDLE only); train  in  1  sampled with start, 1 = run backprop after forward.
REQ-008 x  in  N x BITS  inputs, from hidden-layer y; target  in  BITS  desired output; lr  in  BITS  negative learning rate.
REQ-009 y  out  BITS  neuron output (identity activation).
REQ-010 dz_out  out  BITS  error term dz = y - target, feeds hidden-layer dZ_in.
REQ-011 w_fwd  out  N x BITS  weight snapshot used in forward pass, feeds hidden-layer W_in.
REQ-012 w_out  out  (N+1) x BITS  current weights, index 0 = bias b, index i+1 = weight i.
REQ-013 busy  out  1  high in every state except IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, MAC, ACT, ERR, GRAD, UPD, DONE.
REQ-015 IDLE: start=1 at edge E0 latches x, target, lr, train; copies weights to w_fwd; sets acc=b, idx=0; moves to MAC.
REQ-016 MAC: edges E1..EN each add mul(x[idx], w[idx]) to acc, idx++; at EN moves to ACT.
REQ-017 ACT, edge E(N+1): y <= acc; moves to ERR if train, else DONE.
REQ-018 ERR, edge E(N+2): dz_out <= y - target; GRAD, edge E(N+3): g <= mul(lr, dz_out).
REQ-019 UPD, edges E(N+4)..E(2N+4): w[i] <= w[i] + mul(g, x[i]) for i=0..N-1, then b <= b + g; then DONE.
REQ-020 DONE: done=1 for exactly one cycle; next edge returns to IDLE.
REQ-021 Latency from the start edge to done high: N+1 edges forward-only, 2N+4 edges with train.
REQ-022 mul: full 2*BITS signed product, result bits [BITS+7:8] (truncation toward minus infinity).
REQ-023 acc and all sums are BITS wide.
REQ-024 start or load while busy is ignored; changes to x, target or lr while busy have no effect.
REQ-025 load and start in the same IDLE cycle: load wins, start is ignored.
REQ-026 w_fwd holds until the next accepted start; y and dz_out hold until overwritten.

Reset
REQ-027 rst_n low forces IDLE immediately, including mid-pass.
REQ-028 Reset clears y, dz_out, w_fwd, w_out, acc, g, idx, busy and done to 0.
REQ-029 A pass interrupted by reset leaves no partial weight update visible after reset.

Configuration
REQ-030 Macro NEURON_OUT_SAT_EN defined: every add and every mul result saturates to 0x7FFF / 0x8000 on overflow.
REQ-031 Macro not defined: additions and mul results wrap modulo 2^BITS.

Structure
REQ-032 Shared package neuron_pkg holds BITS, FRAC=8, the fixed-point word typedef, the FSM state enum, and the add/saturate helper functions.
REQ-033 One sub-module, fxp_mul: the single shared signed Q8.8 multiplier, rescaling plus macro-controlled saturation.
REQ-034 MAC, GRAD and UPD time-share fxp_mul.

Verification (N=6, Q8.8)
REQ-035 Forward: load w=0x0080 all, b=0x0040; start, train=0, x=0x0100 all -> y=0x0340, done 7 edges after start, w_out unchanged.
REQ-036 Train: same, target=0x0300, lr=0xFF80, train=1 -> dz_out=0x0040; w_out weights=0x0060, bias=0x0020; w_fwd=0x0080; done 16 edges after start.
REQ-037 Overflow: w=0x7F00 all, b=0, x=0x0100 all -> y=0x7FFF with NEURON_OUT_SAT_EN, y=0xFA00 without.
REQ-038 Busy rules: start and load pulsed during MAC -> ignored, latency and results identical to REQ-035.
REQ-039 Reset mid-UPD: rst_n low at edge E(N+6) -> all outputs 0, IDLE, busy=0; a following load+start reproduces REQ-036.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared fixed-point definitions for the neuron output layer (Q8.8 words, FSM states, add helpers).
// Build option NEURON_OUT_SAT_EN: defined -> saturating arithmetic, undefined -> wrap modulo 2^BITS.
package neuron_pkg;

    localparam int BITS = 16;
    localparam int FRAC = 8;

    typedef logic signed [BITS-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_ACT  = 3'd2,
        S_ERR  = 3'd3,
        S_GRAD = 3'd4,
        S_UPD  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam word_t WORD_MAX = {1'b0, {(BITS-1){1'b1}}};
    localparam word_t WORD_MIN = {1'b1, {(BITS-1){1'b0}}};

    // Clamp to the rail selected by the sign of the true result when it overflowed.
    function automatic word_t saturate(input logic neg, input logic ovf, input word_t v);
        if (ovf) return neg ? WORD_MIN : WORD_MAX;
        return v;
    endfunction

    function automatic word_t fxp_add(input word_t a, input word_t b);
`ifdef NEURON_OUT_SAT_EN
        logic [BITS:0] s;
        s = {a[BITS-1], a} + {b[BITS-1], b};
        return saturate(s[BITS], s[BITS] != s[BITS-1], s[BITS-1:0]);
`else
        return a + b;
`endif
    endfunction

    function automatic word_t fxp_sub(input word_t a, input word_t b);
`ifdef NEURON_OUT_SAT_EN
        logic [BITS:0] s;
        s = {a[BITS-1], a} - {b[BITS-1], b};
        return saturate(s[BITS], s[BITS] != s[BITS-1], s[BITS-1:0]);
`else
        return a - b;
`endif
    endfunction

endpackage

// File: rtl/fxp_mul.sv
// Shared signed Q8.8 multiplier: full product, keep bits [BITS+FRAC-1:FRAC] (floor rounding).
// Build option NEURON_OUT_SAT_EN: defined -> clamp out-of-range results, undefined -> wrap.
module fxp_mul
    import neuron_pkg::*;
(
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic [BITS-1:0] o_p
);

    logic signed [2*BITS-1:0] w_prod;
    logic                     w_unused;

    assign w_prod = $signed(i_a) * $signed(i_b);

`ifdef NEURON_OUT_SAT_EN
    logic w_ovf;
    // The kept field is valid only if every bit above it repeats its sign bit.
    assign w_ovf    = !((&w_prod[2*BITS-1:BITS+FRAC-1]) || !(|w_prod[2*BITS-1:BITS+FRAC-1]));
    assign o_p      = saturate(w_prod[2*BITS-1], w_ovf, w_prod[BITS+FRAC-1:FRAC]);
    assign w_unused = ^w_prod[FRAC-1:0];
`else
    assign o_p      = w_prod[BITS+FRAC-1:FRAC];
    assign w_unused = ^{w_prod[2*BITS-1:BITS+FRAC], w_prod[FRAC-1:0]};
`endif

endmodule

// File: rtl/neuron_output.sv
// Output-layer neuron: serial MAC forward pass, optional one-step gradient update of weights and bias.
// BITS must match neuron_pkg::BITS; build option NEURON_OUT_SAT_EN selects saturating arithmetic.
module neuron_output #(
    parameter int N    = 6,
    parameter int BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [N*BITS-1:0]   w_in,
    input  logic [BITS-1:0]     b_in,
    input  logic                start,
    input  logic                train,
    input  logic [N*BITS-1:0]   x,
    input  logic [BITS-1:0]     target,
    input  logic [BITS-1:0]     lr,
    output logic [BITS-1:0]     y,
    output logic [BITS-1:0]     dz_out,
    output logic [N*BITS-1:0]   w_fwd,
    output logic [(N+1)*BITS-1:0] w_out,
    output logic                busy,
    output logic                done
);
    import neuron_pkg::*;

    localparam int IDX_W = $clog2(N + 1);

    state_t           r_state;
    word_t            r_w  [N];
    word_t            r_wf [N];
    word_t            r_x  [N];
    word_t            r_b;
    word_t            r_target;
    word_t            r_lr;
    logic             r_train;
    word_t            r_acc;
    word_t            r_g;
    word_t            r_y;
    word_t            r_dz;
    logic [IDX_W-1:0] r_idx;

    word_t            w_sel_x;
    word_t            w_sel_w;
    word_t            w_mul_a;
    word_t            w_mul_b;
    word_t            w_prod;

    // MAC, GRAD and UPD share one multiplier; operands are steered by state.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sel_x = '0;
        w_sel_w = '0;
        w_mul_a = '0;
        w_mul_b = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_x = r_x[i];
                w_sel_w = r_w[i];
            end
        end
        case (r_state)
            S_MAC:   begin w_mul_a = w_sel_x; w_mul_b = w_sel_w; end
            S_GRAD:  begin w_mul_a = r_lr;    w_mul_b = r_dz;    end
            S_UPD:   begin w_mul_a = r_g;     w_mul_b = w_sel_x; end
            default: begin w_mul_a = '0;      w_mul_b = '0;      end
        endcase
    end

    fxp_mul u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_prod)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    // NOTE: the weight arrays are flops, not RAM, and are cleared by reset so an aborted update leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < N; i++) begin
                r_w[i]  <= '0;
                r_wf[i] <= '0;
                r_x[i]  <= '0;
            end
            r_b      <= '0;
            r_target <= '0;
            r_lr     <= '0;
            r_train  <= 1'b0;
            r_acc    <= '0;
            r_g      <= '0;
            r_y      <= '0;
            r_dz     <= '0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        for (int i = 0; i < N; i++) r_w[i] <= w_in[i*BITS +: BITS];
                        r_b <= b_in;
                    end else if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r_x[i]  <= x[i*BITS +: BITS];
                            r_wf[i] <= r_w[i];
                        end
                        r_target <= target;
                        r_lr     <= lr;
                        r_train  <= train;
                        r_acc    <= r_b;
                        r_idx    <= '0;
                        r_state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= fxp_add(r_acc, w_prod);
                    if (r_idx == IDX_W'(N - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_ACT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_ACT: begin
                    r_y     <= r_acc;
                    r_state <= r_train ? S_ERR : S_DONE;
                end
                S_ERR: begin
                    r_dz    <= fxp_sub(r_y, r_target);
                    r_state <= S_GRAD;
                end
                S_GRAD: begin
                    r_g     <= w_prod;
                    r_idx   <= '0;
                    r_state <= S_UPD;
                end
                S_UPD: begin
                    // Weights first (one per edge), bias on the final step.
                    if (r_idx == IDX_W'(N)) begin
                        r_b     <= fxp_add(r_b, r_g);
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (r_idx == IDX_W'(i)) r_w[i] <= fxp_add(r_w[i], w_prod);
                        end
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign w_fwd[gi*BITS +: BITS]     = r_wf[gi];
        assign w_out[(gi+1)*BITS +: BITS] = r_w[gi];
    end
    assign w_out[BITS-1:0] = r_b;

    assign y      = r_y;
    assign dz_out = r_dz;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_neuron_output.sv
// Self-checking bench for neuron_output (N=6, Q8.8): arithmetic model plus pinned directed vectors.
// Works in both builds; expectations follow NEURON_OUT_SAT_EN.
module tb_neuron_output;

    localparam int N       = 6;
    localparam int LAT_FWD = N + 1;
    localparam int LAT_TRN = 2 * N + 4;

    typedef logic signed [15:0] sw_t;

    logic                 clk;
    logic                 rst_n;
    logic                 load;
    logic [N*16-1:0]      w_in;
    logic [15:0]          b_in;
    logic                 start;
    logic                 train;
    logic [N*16-1:0]      x;
    logic [15:0]          target;
    logic [15:0]          lr;
    logic [15:0]          y;
    logic [15:0]          dz_out;
    logic [N*16-1:0]      w_fwd;
    logic [(N+1)*16-1:0]  w_out;
    logic                 busy;
    logic                 done;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 0;

    neuron_output #(.N(N), .BITS(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .w_in   (w_in),
        .b_in   (b_in),
        .start  (start),
        .train  (train),
        .x      (x),
        .target (target),
        .lr     (lr),
        .y      (y),
        .dz_out (dz_out),
        .w_fwd  (w_fwd),
        .w_out  (w_out),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- arithmetic model ----------------
    function automatic sw_t m_fix(input longint v);
`ifdef NEURON_OUT_SAT_EN
        if (v > 32767)  return 16'sh7FFF;
        if (v < -32768) return 16'sh8000;
`endif
        return sw_t'(v);
    endfunction

    function automatic sw_t m_mul(input sw_t a, input sw_t b);
        longint p;
        p = longint'(a) * longint'(b);
        return m_fix(p >>> 8);
    endfunction

    function automatic sw_t m_add(input sw_t a, input sw_t b);
        return m_fix(longint'(a) + longint'(b));
    endfunction

    function automatic sw_t m_sub(input sw_t a, input sw_t b);
        return m_fix(longint'(a) - longint'(b));
    endfunction

    // Committed values (m_*) and the results of the pass in flight (p_*).
    sw_t m_w [N], m_wf [N], p_w [N];
    sw_t m_b, m_y, m_dz, p_b, p_y, p_dz;
    sw_t t_acc, t_dz, t_g;
    bit  m_act;
    int  m_k, m_lat;

    // Pass timeline: k counts edges since the accepted start; done shows when k reaches the latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_w[i] <= '0; m_wf[i] <= '0; p_w[i] <= '0;
            end
            m_b <= '0; m_y <= '0; m_dz <= '0;
            p_b <= '0; p_y <= '0; p_dz <= '0;
            m_act <= 1'b0; m_k <= 0; m_lat <= 0;
        end else if (m_act) begin
            if (m_k == m_lat) begin
                m_act <= 1'b0;
                m_y   <= p_y;
                m_dz  <= p_dz;
                m_b   <= p_b;
                for (int i = 0; i < N; i++) m_w[i] <= p_w[i];
            end else begin
                m_k <= m_k + 1;
            end
        end else if (load) begin
            for (int i = 0; i < N; i++) m_w[i] <= sw_t'(w_in[i*16 +: 16]);
            m_b <= sw_t'(b_in);
        end else if (start) begin
            t_acc = m_b;
            for (int i = 0; i < N; i++) t_acc = m_add(t_acc, m_mul(sw_t'(x[i*16 +: 16]), m_w[i]));
            p_y <= t_acc;
            for (int i = 0; i < N; i++) m_wf[i] <= m_w[i];
            if (train) begin
                t_dz = m_sub(t_acc, sw_t'(target));
                t_g  = m_mul(sw_t'(lr), t_dz);
                p_dz <= t_dz;
                for (int i = 0; i < N; i++) p_w[i] <= m_add(m_w[i], m_mul(t_g, sw_t'(x[i*16 +: 16])));
                p_b   <= m_add(m_b, t_g);
                m_lat <= LAT_TRN;
            end else begin
                p_dz <= m_dz;
                for (int i = 0; i < N; i++) p_w[i] <= m_w[i];
                p_b   <= m_b;
                m_lat <= LAT_FWD;
            end
            m_act <= 1'b1;
            m_k   <= 0;
        end
    end

    // Compare every cycle, half a period away from the active edge.
    always @(negedge clk) begin
        logic [15:0]         ey, ed;
        logic [(N+1)*16-1:0] ewo;
        logic [N*16-1:0]     ewf;
        if (chk_on) begin
            ey = (m_act && m_k >= N + 1) ? p_y  : m_y;
            ed = (m_act && m_k >= N + 2) ? p_dz : m_dz;
            ewo[15:0] = (m_act && m_k >= 2 * N + 4) ? p_b : m_b;
            for (int i = 0; i < N; i++) begin
                ewo[(i+1)*16 +: 16] = (m_act && m_k >= N + 4 + i) ? p_w[i] : m_w[i];
                ewf[i*16 +: 16]     = m_wf[i];
            end
            check("busy",   busy,   m_act);
            check("done",   done,   m_act && (m_k == m_lat));
            check("y",      y,      ey);
            check("dz_out", dz_out, ed);
            check("w_out",  w_out,  ewo);
            check("w_fwd",  w_fwd,  ewf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [N*16-1:0] wv, input logic [15:0] bv);
        w_in = wv;
        b_in = bv;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Returns edges from the start edge to done high; inj pokes start/load/x/lr mid-MAC.
    task automatic run_pass(input bit trn, input bit inj, output int lat);
        logic [N*16-1:0] x_keep;
        x_keep = x;
        train  = trn;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
            if (inj && lat == 2) begin
                start  = 1'b1;
                load   = 1'b1;
                w_in   = {N{16'h1234}};
                x      = {N{16'h0777}};
                target = 16'h5555;
                lr     = 16'h0100;
            end else if (inj && lat == 3) begin
                start = 1'b0;
                load  = 1'b0;
            end
        end
        if (!done) check("done_timeout", done, 1'b1);
        tick();
        x = x_keep;
    endtask

    initial begin
        int lat;
        rst_n = 1'b1; load = 1'b0; start = 1'b0; train = 1'b0;
        w_in = '0; b_in = '0; x = '0; target = '0; lr = '0;
        #3 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        check("rst_y",     y,     16'h0000);
        check("rst_busy",  busy,  1'b0);
        check("rst_w_out", w_out, '0);
        #8 rst_n = 1'b1;
        tick();

        // Forward pass
        do_load({N{16'h0080}}, 16'h0040);
        x = {N{16'h0100}}; target = 16'h0300; lr = 16'hFF80;
        run_pass(1'b0, 1'b0, lat);
        check("fwd_lat",   lat,   LAT_FWD);
        check("fwd_y",     y,     16'h0340);
        check("fwd_w_out", w_out, {{N{16'h0080}}, 16'h0040});

        // Same pass with start/load and input changes while busy
        run_pass(1'b0, 1'b1, lat);
        target = 16'h0300; lr = 16'hFF80;
        check("busy_lat",   lat,   LAT_FWD);
        check("busy_y",     y,     16'h0340);
        check("busy_w_out", w_out, {{N{16'h0080}}, 16'h0040});

        // Training pass
        run_pass(1'b1, 1'b0, lat);
        check("trn_lat",   lat,    LAT_TRN);
        check("trn_y",     y,      16'h0340);
        check("trn_dz",    dz_out, 16'h0040);
        check("trn_w_out", w_out,  {{N{16'h0060}}, 16'h0020});
        check("trn_w_fwd", w_fwd,  {N{16'h0080}});

        // load and start together: load wins
        w_in = {N{16'h0100}}; b_in = 16'h0000;
        load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        check("ls_busy",  busy,  1'b0);
        check("ls_w_out", w_out, {{N{16'h0100}}, 16'h0000});
        tick();
        check("ls_busy2", busy,  1'b0);

        // Mixed signs, trained against the model
        do_load({16'h0010, 16'hFFC0, 16'h0200, 16'h0040, 16'hFF00, 16'h0180}, 16'hFF80);
        x = {16'hFFF0, 16'h0300, 16'h0100, 16'hFF00, 16'h0080, 16'h0200};
        target = 16'h0100; lr = 16'hFFC0;
        run_pass(1'b1, 1'b0, lat);
        check("mix_lat", lat, LAT_TRN);
        x = {16'h0040, 16'hFE00, 16'h0100, 16'h0280, 16'hFFA0, 16'h0010};
        run_pass(1'b0, 1'b0, lat);

        // Reset in the middle of the weight update
        do_load({N{16'h0080}}, 16'h0040);
        x = {N{16'h0100}}; target = 16'h0300; lr = 16'hFF80; train = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N + 6) tick();
        rst_n = 1'b0;
        #2;
        check("mid_rst_y",     y,      16'h0000);
        check("mid_rst_dz",    dz_out, 16'h0000);
        check("mid_rst_w_out", w_out,  '0);
        check("mid_rst_w_fwd", w_fwd,  '0);
        check("mid_rst_busy",  busy,   1'b0);
        check("mid_rst_done",  done,   1'b0);
        rst_n = 1'b1;
        tick();
        do_load({N{16'h0080}}, 16'h0040);
        run_pass(1'b1, 1'b0, lat);
        check("rtrn_lat",   lat,    LAT_TRN);
        check("rtrn_dz",    dz_out, 16'h0040);
        check("rtrn_w_out", w_out,  {{N{16'h0060}}, 16'h0020});
        check("rtrn_w_fwd", w_fwd,  {N{16'h0080}});

        // Accumulator overflow
        do_load({N{16'h7F00}}, 16'h0000);
        x = {N{16'h0100}};
        run_pass(1'b0, 1'b0, lat);
`ifdef NEURON_OUT_SAT_EN
        check("ovf_y", y, 16'h7FFF);
`else
        check("ovf_y", y, 16'hFA00);
`endif

        tick();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
